// File: rtl/fast_inlier_tally_pkg.sv
// ----------------------------------------------------------------------------
// fast_inlier_tally_pkg
// Shared fixed-point types and helpers for the inlier tally block.
//   fixed_t        : signed Q3.12 point-to-plane distance / threshold
//   inlier_count_t : inlier counter at the default width
//   abs_saturate() : |x| with the most-negative code clamped to max positive
//   hyp_state_t    : hypothesis framing state (idle / inside a hypothesis)
// ----------------------------------------------------------------------------
package fast_inlier_tally_pkg;

    localparam int FIXED_BITS         = 16;
    localparam int FRAC_BITS          = 12;
    localparam int COUNT_BITS_DEFAULT = 16;
    localparam int MODEL_BITS_DEFAULT = 8;

    typedef logic signed [FIXED_BITS-1:0]  fixed_t;
    typedef logic [COUNT_BITS_DEFAULT-1:0] inlier_count_t;

    localparam fixed_t FIXED_MAX = fixed_t'({1'b0, {(FIXED_BITS-1){1'b1}}});
    localparam fixed_t FIXED_MIN = fixed_t'({1'b1, {(FIXED_BITS-1){1'b0}}});

    typedef enum logic {
        HYP_IDLE   = 1'b0,  // next valid sample starts a hypothesis
        HYP_ACTIVE = 1'b1   // inside a hypothesis, waiting for its last sample
    } hyp_state_t;

    // Two's-complement negation of FIXED_MIN overflows back to itself, so it
    // is clamped to FIXED_MAX instead.
    function automatic fixed_t abs_saturate(input fixed_t x);
        if (x == FIXED_MIN) begin
            return FIXED_MAX;
        end else if (x[FIXED_BITS-1]) begin
            return -x;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/fast_inlier_tally_if.sv
// ----------------------------------------------------------------------------
// fast_inlier_tally_if
// Bundles the distance stream, best-tracking control and the result
// handshake of fast_inlier_tally.
//   master : stream producer / result consumer (drives samples, ready)
//   slave  : the tally block (drives results, best tracking, overrun)
// ----------------------------------------------------------------------------
interface fast_inlier_tally_if #(
    parameter int count_bits = 16,
    parameter int model_bits = 8
);
    import fast_inlier_tally_pkg::*;

    // Distance stream (no backpressure)
    logic                  distance_valid;
    fixed_t                distance;
    logic                  distance_last;
    logic [model_bits-1:0] distance_model;
    fixed_t                threshold;
    logic                  clear_best;

    // Per-hypothesis result hold register
    logic                  result_valid;
    logic                  result_ready;
    logic [model_bits-1:0] result_model;
    logic [count_bits-1:0] result_count;
    logic                  result_is_best;

    // Best tracking and status
    logic [model_bits-1:0] best_model;
    logic [count_bits-1:0] best_count;
    logic                  overrun;

    modport master (
        output distance_valid, distance, distance_last, distance_model,
               threshold, clear_best, result_ready,
        input  result_valid, result_model, result_count, result_is_best,
               best_model, best_count, overrun
    );

    modport slave (
        input  distance_valid, distance, distance_last, distance_model,
               threshold, clear_best, result_ready,
        output result_valid, result_model, result_count, result_is_best,
               best_model, best_count, overrun
    );

endinterface

// File: rtl/fast_inlier_tally_fixed_abs_threshold.sv
// ----------------------------------------------------------------------------
// fixed_abs_threshold
// One registered stage: inlier = |distance| <= threshold. The threshold is
// taken straight from the port on the first sample of a hypothesis and
// latched for the remaining samples. Sideband (valid/first/last/model) is
// delayed by the same single stage.
//   clock, reset_n            : clock, async active-low reset
//   in_valid/in_first/in_last : sample framing
//   in_model                  : hypothesis index of the sample
//   distance, threshold       : signed fixed distance and threshold (>=0)
//   out_*                     : framing, model and inlier flag, one cycle later
// ----------------------------------------------------------------------------
module fixed_abs_threshold
    import fast_inlier_tally_pkg::*;
#(
    parameter int model_bits = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [model_bits-1:0] in_model,
    input  fixed_t                distance,
    input  fixed_t                threshold,
    output logic                  out_valid,
    output logic                  out_first,
    output logic                  out_last,
    output logic [model_bits-1:0] out_model,
    output logic                  out_inlier
);

    fixed_t thr_latched;
    fixed_t thr_eff;
    logic   inlier_now;

    // Both operands are non-negative, so the signed compare is a plain magnitude compare.
    assign thr_eff    = in_first ? threshold : thr_latched;
    assign inlier_now = (abs_saturate(distance) <= thr_eff);

    // NOTE: every flop, payload included, is in the async reset so the stage
    // never presents stale framing after reset; non-blocking assignments keep
    // all register updates parallel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            thr_latched <= '0;
            out_valid   <= 1'b0;
            out_first   <= 1'b0;
            out_last    <= 1'b0;
            out_model   <= '0;
            out_inlier  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_first  <= in_first;
                out_last   <= in_last;
                out_model  <= in_model;
                out_inlier <= inlier_now;
                if (in_first) begin
                    thr_latched <= threshold;
                end
            end
        end
    end

endmodule

// File: rtl/fast_inlier_tally.sv
// ----------------------------------------------------------------------------
// fast_inlier_tally
// Counts inliers (|distance| <= threshold) per plane hypothesis on a
// one-sample-per-cycle stream, tracks the best hypothesis and presents one
// result per hypothesis through a valid/ready hold register. The input is
// never stalled; an unaccepted result is overwritten and flagged by overrun.
//   clock, reset_n : clock, async active-low reset
//   bus (slave)    : distance stream, clear_best, result handshake,
//                    best_model/best_count, sticky overrun
// Latency: sample with distance_last in cycle N -> result_valid in cycle N+2.
// ----------------------------------------------------------------------------
module fast_inlier_tally
    import fast_inlier_tally_pkg::*;
#(
    parameter int count_bits = 16,
    parameter int model_bits = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    fast_inlier_tally_if.slave bus
);

    typedef logic [count_bits-1:0] count_t;
    typedef logic [model_bits-1:0] model_t;

    // ---------------------------------------------------------------- framing
    hyp_state_t state_q, state_d;
    logic       sample_first;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HYP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: defaults first so every path assigns every output (no latches).
    always_comb begin
        state_d      = state_q;
        sample_first = 1'b0;
        case (state_q)
            HYP_IDLE: begin
                if (bus.distance_valid) begin
                    sample_first = 1'b1;
                    if (!bus.distance_last) begin
                        state_d = HYP_ACTIVE;
                    end
                end
            end
            HYP_ACTIVE: begin
                if (bus.distance_valid && bus.distance_last) begin
                    state_d = HYP_IDLE;
                end
            end
            default: state_d = HYP_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- stage 1
    logic   s1_valid, s1_first, s1_last, s1_inlier;
    model_t s1_model;

    fixed_abs_threshold #(
        .model_bits (model_bits)
    ) u_abs_threshold (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (bus.distance_valid),
        .in_first   (sample_first),
        .in_last    (bus.distance_last),
        .in_model   (bus.distance_model),
        .distance   (bus.distance),
        .threshold  (bus.threshold),
        .out_valid  (s1_valid),
        .out_first  (s1_first),
        .out_last   (s1_last),
        .out_model  (s1_model),
        .out_inlier (s1_inlier)
    );

    // ---------------------------------------------------------------- stage 2
    count_t acc_q;
    model_t acc_model_q;
    count_t count_base;
    count_t count_next;
    model_t final_model;
    count_t best_ref;
    logic   finalize;
    logic   new_best;
    logic   accept;

    count_t best_count_q, result_count_q;
    model_t best_model_q, result_model_q;
    logic   result_valid_q, result_is_best_q, overrun_q;

    always_comb begin
        // A first sample restarts the count from zero instead of the old total.
        count_base  = s1_first ? '0 : acc_q;
        count_next  = (s1_inlier && (count_base != '1)) ? count_base + count_t'(1) : count_base;
        final_model = s1_first ? s1_model : acc_model_q;
        finalize    = s1_valid && s1_last;
        // A coincident clear takes effect before the finalizing compare.
        best_ref    = bus.clear_best ? '0 : best_count_q;
        new_best    = finalize && (count_next > best_ref);
        accept      = result_valid_q && bus.result_ready;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            acc_model_q <= '0;
        end else if (s1_valid) begin
            acc_q <= count_next;
            if (s1_first) begin
                acc_model_q <= s1_model;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            best_model_q <= '0;
            best_count_q <= '0;
        end else if (new_best) begin
            best_model_q <= final_model;
            best_count_q <= count_next;
        end else if (bus.clear_best) begin
            best_model_q <= '0;
            best_count_q <= '0;
        end
    end

    // Hold register: a finalize always loads, even over an unaccepted result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_valid_q   <= 1'b0;
            result_model_q   <= '0;
            result_count_q   <= '0;
            result_is_best_q <= 1'b0;
            overrun_q        <= 1'b0;
        end else if (finalize) begin
            result_valid_q   <= 1'b1;
            result_model_q   <= final_model;
            result_count_q   <= count_next;
            result_is_best_q <= new_best;
            if (result_valid_q && !bus.result_ready) begin
                overrun_q <= 1'b1;
            end
        end else if (accept) begin
            result_valid_q <= 1'b0;
        end
    end

    assign bus.result_valid   = result_valid_q;
    assign bus.result_model   = result_model_q;
    assign bus.result_count   = result_count_q;
    assign bus.result_is_best = result_is_best_q;
    assign bus.best_model     = best_model_q;
    assign bus.best_count     = best_count_q;
    assign bus.overrun        = overrun_q;

endmodule

// File: tb/tb_fast_inlier_tally.sv
// ----------------------------------------------------------------------------
// tb_fast_inlier_tally
// Self-checking bench for fast_inlier_tally. Expected results come from a
// transaction-level model: per-hypothesis inlier counts are computed from the
// sample list, and the hold register / best tracker are modelled per clock.
// ----------------------------------------------------------------------------
module tb_fast_inlier_tally;
    import fast_inlier_tally_pkg::*;

    localparam int CB = 16;
    localparam int MB = 8;
    localparam int COUNT_MAX = (1 << CB) - 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    fast_inlier_tally_if #(.count_bits(CB), .model_bits(MB)) bus ();

    fast_inlier_tally #(
        .count_bits (CB),
        .model_bits (MB)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit exp_valid, exp_overrun, exp_is_best;
    int exp_model, exp_count, exp_best_model, exp_best_count;
    bit pend_fin;
    int pend_model, pend_count;
    int cur_model, cur_count;

    function automatic int ref_abs(input int d);
        int a;
        a = (d < 0) ? -d : d;
        return (a > 32767) ? 32767 : a;
    endfunction

    function automatic int to_fx(input real r);
        return int'(r * 4096.0);
    endfunction

    task automatic model_reset();
        exp_valid = 0; exp_overrun = 0; exp_is_best = 0;
        exp_model = 0; exp_count = 0; exp_best_model = 0; exp_best_count = 0;
        pend_fin = 0; pend_model = 0; pend_count = 0;
    endtask

    // Advance one clock, applying the hypothesis-level rules to the model.
    task automatic tick();
        bit accept;
        bit b;
        int ref_best;
        accept = exp_valid && bus.result_ready;
        if (pend_fin) begin
            ref_best = bus.clear_best ? 0 : exp_best_count;
            b = pend_count > ref_best;
            if (b) begin
                exp_best_model = pend_model;
                exp_best_count = pend_count;
            end else if (bus.clear_best) begin
                exp_best_model = 0;
                exp_best_count = 0;
            end
            if (exp_valid && !bus.result_ready) exp_overrun = 1;
            exp_valid = 1; exp_model = pend_model; exp_count = pend_count; exp_is_best = b;
        end else begin
            if (bus.clear_best) begin
                exp_best_model = 0;
                exp_best_count = 0;
            end
            if (accept) exp_valid = 0;
        end
        pend_fin   = bus.distance_valid && bus.distance_last;
        pend_model = cur_model;
        pend_count = cur_count;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        bus.distance_valid = 1'b0;
        bus.distance_last  = 1'b0;
        repeat (n) tick();
    endtask

    // Drive one hypothesis. Non-first samples carry junk model/threshold to
    // show those are taken from the first sample only.
    task automatic send_hyp(input int ds[$], input int thr, input int model,
                            input bit close, input bit gaps);
        int cnt = 0;
        foreach (ds[i]) if (ref_abs(ds[i]) <= thr && cnt < COUNT_MAX) cnt++;
        cur_model = model;
        cur_count = cnt;
        foreach (ds[i]) begin
            if (gaps && i > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.distance_valid = 1'b0;
                    bus.distance       = fixed_t'($urandom);
                    bus.distance_last  = 1'b1;
                    tick();
                end
            end
            bus.distance_valid = 1'b1;
            bus.distance       = fixed_t'(ds[i]);
            bus.distance_last  = close && (i == ds.size() - 1);
            bus.distance_model = (i == 0) ? MB'(model) : MB'($urandom_range(0, 255));
            bus.threshold      = (i == 0) ? fixed_t'(thr) : fixed_t'($urandom_range(0, 32767));
            tick();
        end
    endtask

    task automatic apply_reset();
        reset_n            = 1'b0;
        bus.distance_valid = 1'b0;
        bus.distance       = '0;
        bus.distance_last  = 1'b0;
        bus.distance_model = '0;
        bus.threshold      = '0;
        bus.clear_best     = 1'b0;
        bus.result_ready   = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({bus.result_valid, bus.result_model, bus.result_count, bus.result_is_best,
             bus.best_model, bus.best_count, bus.overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b count=%0d best=%0d overrun=%b, all required 0",
                     bus.result_valid, bus.result_count, bus.best_count, bus.overrun);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_basic();
        int ds[$];
        ds = '{to_fx(0.5), to_fx(-0.2), to_fx(0.1), to_fx(-0.9)};
        send_hyp(ds, to_fx(0.3), 5, 1'b1, 1'b0);
        n_checks++;
        if (bus.result_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_early_valid: got %b required 0", bus.result_valid);
        end
        idle(1);
        n_checks++;
        if (bus.result_valid !== 1'b1 || bus.result_count !== CB'(2) || bus.result_model !== MB'(5)) begin
            n_fail++;
            $display("FAIL basic_result: valid=%b count=%0d model=%0d required 1/2/5",
                     bus.result_valid, bus.result_count, bus.result_model);
        end
        n_checks++;
        if (bus.result_is_best !== 1'b1 || bus.best_count !== CB'(2) || bus.best_model !== MB'(5)) begin
            n_fail++;
            $display("FAIL basic_best: is_best=%b best_count=%0d best_model=%0d required 1/2/5",
                     bus.result_is_best, bus.best_count, bus.best_model);
        end
        bus.result_ready = 1'b1;
        idle(1);
        bus.result_ready = 1'b0;
        n_checks++;
        if (bus.result_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_accept_drop: got %b required 0", bus.result_valid);
        end
    endtask

    task automatic test_abs_saturate();
        int ds[$];
        ds = '{-32768};
        send_hyp(ds, 32767, 9, 1'b1, 1'b0);
        idle(1);
        n_checks++;
        if (bus.result_count !== CB'(1) || bus.result_is_best !== 1'b0 || bus.best_count !== CB'(2)) begin
            n_fail++;
            $display("FAIL abs_most_negative: count=%0d is_best=%b best=%0d required 1/0/2",
                     bus.result_count, bus.result_is_best, bus.best_count);
        end
        bus.result_ready = 1'b1;
        idle(1);
        bus.result_ready = 1'b0;
        // Equality with the threshold is an inlier; a tie with best keeps the earlier one.
        ds = '{1229, 1230, -1229};
        send_hyp(ds, 1229, 12, 1'b1, 1'b0);
        idle(1);
        n_checks++;
        if (bus.result_count !== CB'(2) || bus.result_is_best !== 1'b0 || bus.best_model !== MB'(5)) begin
            n_fail++;
            $display("FAIL threshold_edge_tie: count=%0d is_best=%b best_model=%0d required 2/0/5",
                     bus.result_count, bus.result_is_best, bus.best_model);
        end
        bus.result_ready = 1'b1;
        idle(1);
        bus.result_ready = 1'b0;
    endtask

    task automatic test_clear_only();
        bus.clear_best = 1'b1;
        idle(1);
        bus.clear_best = 1'b0;
        n_checks++;
        if (bus.best_count !== CB'(0) || bus.best_model !== MB'(0)) begin
            n_fail++;
            $display("FAIL clear_only: best_count=%0d best_model=%0d required 0/0",
                     bus.best_count, bus.best_model);
        end
    endtask

    task automatic test_back_to_back_overrun();
        int a[$];
        int b[$];
        a = '{0, 100, -100};
        b = '{50, -50, 60, 5000};
        bus.result_ready = 1'b0;
        send_hyp(a, 200, 10, 1'b1, 1'b0);
        send_hyp(b, 100, 11, 1'b1, 1'b0);
        idle(1);
        n_checks++;
        if (bus.overrun !== 1'b1 || bus.result_model !== MB'(11) || bus.result_count !== CB'(3)) begin
            n_fail++;
            $display("FAIL b2b_overrun: overrun=%b model=%0d count=%0d required 1/11/3",
                     bus.overrun, bus.result_model, bus.result_count);
        end
        n_checks++;
        if (bus.result_is_best !== 1'b0 || bus.best_model !== MB'(10) || bus.best_count !== CB'(3)) begin
            n_fail++;
            $display("FAIL b2b_best: is_best=%b best_model=%0d best_count=%0d required 0/10/3",
                     bus.result_is_best, bus.best_model, bus.best_count);
        end
    endtask

    task automatic test_ready_same_cycle();
        int a[$];
        int b[$];
        apply_reset();
        a = '{1, 2, 3};
        b = '{4, 5, 6};
        send_hyp(a, 10, 30, 1'b1, 1'b0);
        send_hyp(b, 10, 31, 1'b1, 1'b0);
        bus.result_ready = 1'b1;
        idle(1);
        bus.result_ready = 1'b0;
        n_checks++;
        if (bus.overrun !== 1'b0 || bus.result_valid !== 1'b1 || bus.result_model !== MB'(31)) begin
            n_fail++;
            $display("FAIL ready_same_cycle: overrun=%b valid=%b model=%0d required 0/1/31",
                     bus.overrun, bus.result_valid, bus.result_model);
        end
        n_checks++;
        if (bus.result_is_best !== 1'b0 || bus.best_model !== MB'(30)) begin
            n_fail++;
            $display("FAIL ready_same_cycle_best: is_best=%b best_model=%0d required 0/30",
                     bus.result_is_best, bus.best_model);
        end
        bus.result_ready = 1'b1;
        idle(1);
        bus.result_ready = 1'b0;
    endtask

    task automatic test_clear_with_finalize();
        int a[$];
        int b[$];
        a = '{0, 0, 0, 0, 0};
        b = '{100, 7};
        send_hyp(a, 0, 40, 1'b1, 1'b1);
        idle(1);
        n_checks++;
        if (bus.best_count !== CB'(5)) begin
            n_fail++; $display("FAIL clear_setup_best: got %0d required 5", bus.best_count);
        end
        bus.result_ready = 1'b1;
        idle(1);
        bus.result_ready = 1'b0;
        send_hyp(b, 50, 41, 1'b1, 1'b0);
        bus.clear_best = 1'b1;
        idle(1);
        bus.clear_best = 1'b0;
        n_checks++;
        if (bus.best_count !== CB'(1) || bus.best_model !== MB'(41) ||
            bus.result_is_best !== 1'b1 || bus.result_count !== CB'(1)) begin
            n_fail++;
            $display("FAIL clear_with_finalize: best=%0d best_model=%0d is_best=%b count=%0d required 1/41/1/1",
                     bus.best_count, bus.best_model, bus.result_is_best, bus.result_count);
        end
    endtask

    task automatic test_reset_mid();
        int a[$];
        int b[$];
        a = '{0, 0, 0};
        b = '{0, 999};
        send_hyp(a, 10, 50, 1'b0, 1'b0);
        bus.distance_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({bus.result_valid, bus.result_model, bus.result_count, bus.result_is_best,
             bus.best_model, bus.best_count, bus.overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: valid=%b count=%0d best=%0d required 0",
                     bus.result_valid, bus.result_count, bus.best_count);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        send_hyp(b, 10, 51, 1'b1, 1'b0);
        idle(1);
        n_checks++;
        if (bus.result_valid !== 1'b1 || bus.result_count !== CB'(1) ||
            bus.result_model !== MB'(51) || bus.best_count !== CB'(1)) begin
            n_fail++;
            $display("FAIL reset_mid_recount: valid=%b count=%0d model=%0d best=%0d required 1/1/51/1",
                     bus.result_valid, bus.result_count, bus.result_model, bus.best_count);
        end
    endtask

    task automatic test_random();
        int ds[$];
        int len;
        for (int h = 0; h < 40; h++) begin
            ds.delete();
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 15) == 0) ds.push_back(-32768);
                else ds.push_back(int'($urandom_range(0, 8000)) - 4000);
            end
            bus.result_ready = 1'($urandom_range(0, 1));
            send_hyp(ds, $urandom_range(0, 4000), 60 + h, 1'b1, 1'b1);
            bus.clear_best = ($urandom_range(0, 7) == 0);
            idle(1);
            bus.clear_best = 1'b0;
            n_checks++;
            if (bus.result_valid !== exp_valid || bus.result_model !== MB'(exp_model) ||
                bus.result_count !== CB'(exp_count) || bus.result_is_best !== exp_is_best) begin
                n_fail++;
                $display("FAIL random_result[%0d]: valid=%b model=%0d count=%0d best=%b required %b/%0d/%0d/%b",
                         h, bus.result_valid, bus.result_model, bus.result_count, bus.result_is_best,
                         exp_valid, exp_model, exp_count, exp_is_best);
            end
            n_checks++;
            if (bus.best_model !== MB'(exp_best_model) || bus.best_count !== CB'(exp_best_count) ||
                bus.overrun !== exp_overrun) begin
                n_fail++;
                $display("FAIL random_best[%0d]: best_model=%0d best_count=%0d overrun=%b required %0d/%0d/%b",
                         h, bus.best_model, bus.best_count, bus.overrun,
                         exp_best_model, exp_best_count, exp_overrun);
            end
        end
    endtask

    initial begin
        cur_model = 0;
        cur_count = 0;
        test_reset();
        test_basic();
        test_abs_saturate();
        test_clear_only();
        test_back_to_back_overrun();
        test_ready_same_cycle();
        test_clear_with_finalize();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
